// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP datapath blocks.
//   word_width : default data/weight/bias word width in bits
//   frac_width : default number of fractional bits in a word
//   nd_state_t : neuron_driver sequencing state, 3-bit encoding
package mlp_pkg;

  localparam int unsigned word_width = 16;
  localparam int unsigned frac_width = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FIRE = 3'd2,
    WAIT = 3'd3,
    HOLD = 3'd4
  } nd_state_t;

endpackage

// File: rtl/Register.sv
// Generic storage register with load enable.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears q
//   en  : load d into q on the next rising edge
//   d   : data in
//   q   : stored value
module Register #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/neuron_driver_ctrl.sv
// Sequencer for neuron_driver: collects input beats, pulses the neuron out
// of reset, waits (with timeout) for its result and hands it downstream.
//   clk, rst, clk_en : clock, async active-high reset, clock enable
//   in_valid         : upstream beat offered
//   nrn_ready        : neuron result valid
//   out_ready        : downstream accepts result
//   in_ready         : beat can be accepted this cycle
//   beat             : beat transfers on this edge
//   beat_idx         : lane index of the current beat
//   capture          : load neuron result on this edge
//   nrn_rst          : neuron reset/hold
//   out_valid, busy  : result held / not idle
//   error            : sticky neuron timeout flag
//
// state | meaning
// IDLE  | waiting for beat 0, buses keep last vector
// LOAD  | collecting beats 1..number_of_input-1
// FIRE  | one enabled cycle, neuron still in reset
// WAIT  | neuron running, waiting for nrn_ready or timeout
// HOLD  | result presented until out_ready
module neuron_driver_ctrl
  import mlp_pkg::*;
#(
  parameter int number_of_input       = 2,
  parameter int clog2_number_of_input = 1,
  parameter int timeout               = 2*number_of_input+4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clk_en,
  input  logic                             in_valid,
  input  logic                             nrn_ready,
  input  logic                             out_ready,
  output logic                             in_ready,
  output logic                             beat,
  output logic [clog2_number_of_input-1:0] beat_idx,
  output logic                             capture,
  output logic                             nrn_rst,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             error
);

  localparam int cnt_w = (timeout < 2) ? 1 : $clog2(timeout);
  localparam logic [clog2_number_of_input-1:0] last_idx =
    clog2_number_of_input'(number_of_input - 1);
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(timeout - 1);

  nd_state_t                        state, state_nxt;
  logic [clog2_number_of_input-1:0] idx, idx_nxt;
  logic [cnt_w-1:0]                 wait_cnt, wait_cnt_nxt;
  logic                             err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      wait_cnt <= '0;
      error    <= 1'b0;
    end else if (clk_en) begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      wait_cnt <= wait_cnt_nxt;
      error    <= err_nxt;
    end
  end

  // in_ready folds in clk_en so a beat can only transfer on an edge that
  // actually updates the storage.
  assign in_ready  = (state == IDLE || state == LOAD) && clk_en && !rst;
  assign beat      = in_valid && in_ready;
  assign beat_idx  = idx;
  assign nrn_rst   = (state == IDLE) || (state == LOAD) || (state == FIRE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = error;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        if (beat) begin
          if (number_of_input == 1) begin
            state_nxt = FIRE;
          end else begin
            state_nxt = LOAD;
            idx_nxt   = clog2_number_of_input'(1);
          end
        end
      end
      LOAD: begin
        if (beat) begin
          if (idx == last_idx) begin
            state_nxt = FIRE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      FIRE: begin
        state_nxt    = WAIT;
        wait_cnt_nxt = '0;
      end
      WAIT: begin
        if (nrn_ready) begin
          capture   = clk_en;
          state_nxt = HOLD;
        end else if (wait_cnt == last_cnt) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/neuron_driver.sv
// Feeds one neuron: gathers number_of_input (data, weight) beats plus a
// bias, releases the neuron from reset and returns its result downstream.
//   clk, rst, clk_en        : clock, async active-high reset, clock enable
//   in_valid/in_ready       : input beat handshake
//   in_data, in_weight      : beat words, lane = beat index
//   in_bias                 : bias, taken from beat 0 only
//   nrn_datas, nrn_weights  : packed lane buses to the neuron
//   nrn_bias, nrn_rst       : neuron bias and reset/hold
//   nrn_result, nrn_ready   : neuron result and its valid
//   out_valid/out_ready     : result handshake
//   out_result              : captured neuron result
//   busy, error             : not idle / sticky timeout
// m is carried for the neuron's fixed-point format; nothing here uses it.
module neuron_driver
  import mlp_pkg::*;
#(
  parameter int n                     = word_width,
  parameter int m                     = frac_width,
  parameter int number_of_input       = 2,
  parameter int clog2_number_of_input = 1,
  parameter int timeout               = 2*number_of_input+4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [n-1:0]                 in_data,
  input  logic [n-1:0]                 in_weight,
  input  logic [n-1:0]                 in_bias,
  output logic [number_of_input*n-1:0] nrn_datas,
  output logic [number_of_input*n-1:0] nrn_weights,
  output logic [n-1:0]                 nrn_bias,
  output logic                         nrn_rst,
  input  logic [n-1:0]                 nrn_result,
  input  logic                         nrn_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [n-1:0]                 out_result,
  output logic                         busy,
  output logic                         error
);

  logic                             beat;
  logic                             capture;
  logic [clog2_number_of_input-1:0] beat_idx;

  neuron_driver_ctrl #(
    .number_of_input       (number_of_input),
    .clog2_number_of_input (clog2_number_of_input),
    .timeout               (timeout)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .in_valid  (in_valid),
    .nrn_ready (nrn_ready),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .beat      (beat),
    .beat_idx  (beat_idx),
    .capture   (capture),
    .nrn_rst   (nrn_rst),
    .out_valid (out_valid),
    .busy      (busy),
    .error     (error)
  );

  for (genvar k = 0; k < number_of_input; k++) begin : g_lane
    logic lane_we;
    assign lane_we = beat && (beat_idx == clog2_number_of_input'(k));

    Register #(.width(n)) u_data (
      .clk (clk), .rst (rst), .en (lane_we),
      .d   (in_data), .q (nrn_datas[k*n +: n])
    );
    Register #(.width(n)) u_weight (
      .clk (clk), .rst (rst), .en (lane_we),
      .d   (in_weight), .q (nrn_weights[k*n +: n])
    );
  end

  Register #(.width(n)) u_bias (
    .clk (clk), .rst (rst), .en (beat && (beat_idx == '0)),
    .d   (in_bias), .q (nrn_bias)
  );

  Register #(.width(n)) u_result (
    .clk (clk), .rst (rst), .en (capture),
    .d   (nrn_result), .q (out_result)
  );

endmodule

// File: tb/tb_neuron_driver.sv
// Self-checking bench for neuron_driver with a behavioural neuron attached.
module tb_neuron_driver;

  localparam int NW   = 16;
  localparam int NF   = 8;
  localparam int NIN  = 2;
  localparam int TOUT = 8;

  logic              clk = 1'b0;
  logic              rst, clk_en, in_valid, in_ready;
  logic [NW-1:0]     in_data, in_weight, in_bias;
  logic [NIN*NW-1:0] nrn_datas, nrn_weights;
  logic [NW-1:0]     nrn_bias, nrn_result, out_result;
  logic              nrn_rst, nrn_ready, out_valid, out_ready, busy, error;

  int n_checks = 0;
  int n_pass   = 0;

  // neuron model controls
  bit nrn_ok  = 1'b1;
  int nrn_lat = 0;
  int lat_cnt;

  // scoreboard state
  logic [NW-1:0] last_result = '0;
  bit            exp_error   = 1'b0;
  bit            tog         = 1'b0;

  always #5 clk = ~clk;

  neuron_driver #(
    .n(NW), .m(NF), .number_of_input(NIN), .clog2_number_of_input(1), .timeout(TOUT)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight), .in_bias(in_bias),
    .nrn_datas(nrn_datas), .nrn_weights(nrn_weights), .nrn_bias(nrn_bias),
    .nrn_rst(nrn_rst), .nrn_result(nrn_result), .nrn_ready(nrn_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy), .error(error)
  );

  // Q8.8 dot product plus bias, ReLU, saturate to the positive range.
  function automatic logic [NW-1:0] neuron_eval(input logic [NIN*NW-1:0] d,
                                                input logic [NIN*NW-1:0] w,
                                                input logic [NW-1:0] b);
    longint acc = 0;
    for (int i = 0; i < NIN; i++)
      acc += longint'($signed(d[i*NW +: NW])) * longint'($signed(w[i*NW +: NW]));
    acc = (acc >>> NF) + longint'($signed(b));
    if (acc < 0) acc = 0;
    if (acc > 32767) acc = 32767;
    return acc[NW-1:0];
  endfunction

  // Behavioural neuron: computes from the buses, raises ready nrn_lat
  // enabled cycles after being released from reset.
  always @(posedge clk or posedge rst) begin
    if (rst)          lat_cnt <= 0;
    else if (nrn_rst) lat_cnt <= 0;
    else if (clk_en)  lat_cnt <= lat_cnt + 1;
  end
  always_comb begin
    nrn_result = neuron_eval(nrn_datas, nrn_weights, nrn_bias);
    nrn_ready  = nrn_ok && !nrn_rst && (lat_cnt >= nrn_lat);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit pick_en(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) begin tog = ~tog; return tog; end
    return 1'($urandom_range(0, 1));
  endfunction

  // One full vector. mode: 0 continuous clk_en, 1 toggling, 2 random.
  task automatic run_vec(input logic [NW-1:0] d0, input logic [NW-1:0] d1,
                         input logic [NW-1:0] w0, input logic [NW-1:0] w1,
                         input logic [NW-1:0] b, input int mode, input int lat,
                         input int stall, input bit ok);
    logic [NW-1:0] exp_res;
    int k = 0, guard = 0, en_edges = 0, bad = 0, e = 0;
    bit started = 0, done = 0;
    nrn_lat = lat;
    nrn_ok  = ok;
    tog     = 1'b0;
    exp_res = neuron_eval({d1, d0}, {w1, w0}, b);
    while (k < NIN && guard < 200) begin
      clk_en    = pick_en(mode);
      in_valid  = 1'b1;
      in_data   = (k == 0) ? d0 : d1;
      in_weight = (k == 0) ? w0 : w1;
      in_bias   = (k == 0) ? b : ~b;
      #1;
      if (in_ready) begin k++; started = 1; end
      if (started && clk_en) en_edges++;
      @(posedge clk); #1; guard++;
    end
    in_valid = 1'b0;
    check("beats_accepted", k, NIN);
    check("nrn_datas", nrn_datas, {d1, d0});
    check("nrn_weights", nrn_weights, {w1, w0});
    check("nrn_bias", nrn_bias, b);
    if (ok) begin
      guard = 0;
      while (!out_valid && guard < 200) begin
        clk_en = pick_en(mode); #1;
        if (in_ready) bad++;
        if (clk_en) en_edges++;
        @(posedge clk); #1; guard++;
      end
      check("out_valid", out_valid, 1);
      check("out_result", out_result, exp_res);
      check("enabled_cycles", en_edges, NIN + 2 + lat);
      check("error_sticky", error, exp_error);
      out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        clk_en = pick_en(mode);
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || out_result !== exp_res || in_ready !== 1'b0) bad++;
      end
      out_ready = 1'b1;
      guard = 0;
      while (!done && guard < 200) begin
        clk_en = pick_en(mode); #1;
        done = clk_en;
        if (in_ready) bad++;
        @(posedge clk); #1; guard++;
      end
      out_ready = 1'b0;
      clk_en = 1'b1; #1;
      check("no_input_while_busy", bad, 0);
      check("idle_after_accept", {out_valid, busy}, 2'b00);
      check("in_ready_after_accept", in_ready, 1);
      last_result = exp_res;
    end else begin
      // FIRE takes one enabled edge, then timeout enabled edges in WAIT.
      guard = 0;
      while (e < 1 + TOUT && guard < 200) begin
        clk_en = pick_en(mode); #1;
        if (in_ready) bad++;
        if (clk_en) e++;
        @(posedge clk); #1; guard++;
        if (error !== (exp_error || e >= 1 + TOUT)) bad++;
        if (busy !== (e < 1 + TOUT)) bad++;
      end
      check("timeout_edges", e, 1 + TOUT);
      check("timeout_timing", bad, 0);
      check("error_set", error, 1);
      check("idle_after_timeout", busy, 0);
      check("result_kept", out_result, last_result);
      exp_error = 1'b1;
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_in_ready"}, in_ready, 0);
    check({pfx, "_nrn_rst"}, nrn_rst, 1);
    check({pfx, "_out_valid"}, out_valid, 0);
    check({pfx, "_out_result"}, out_result, 0);
    check({pfx, "_buses"}, {nrn_datas, nrn_weights, nrn_bias}, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_error"}, error, 0);
  endtask

  function automatic logic [NW-1:0] rnd_word();
    int v = int'($urandom_range(0, 2047)) - 1024;
    return NW'(v);
  endfunction

  initial begin
    rst = 1'b1; clk_en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_weight = '0; in_bias = '0;
    #1;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // basic vector and ReLU clamp
    run_vec(16'h0100, 16'h0200, 16'h0100, 16'h0080, 16'h0000, 0, 2, 0, 1);
    check("basic_value", out_result, 16'h0200);
    run_vec(16'h0100, 16'h0100, 16'hFF00, 16'hFF00, 16'h0000, 0, 0, 0, 1);
    check("relu_value", out_result, 16'h0000);

    // backpressure
    run_vec(16'h0180, 16'h0040, 16'h0200, 16'h0100, 16'h0010, 0, 1, 5, 1);

    // timeout, then a normal vector
    run_vec(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 0, 0, 0, 0);
    run_vec(16'h0100, 16'h0200, 16'h0100, 16'h0080, 16'h0000, 0, 1, 0, 1);

    // reset mid-LOAD after beat 0
    clk_en = 1'b1; in_valid = 1'b1; in_data = 16'h7777; in_weight = 16'h3333; in_bias = 16'h1111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("load_after_beat0", busy, 1);
    rst = 1'b1; #1;
    check_reset_values("midload");
    @(posedge clk); #1 rst = 1'b0;
    exp_error = 1'b0; last_result = '0;
    run_vec(16'h0080, 16'h0100, 16'h0200, 16'h0300, 16'h0020, 0, 0, 0, 1);
    check("fresh_value", out_result, 16'h0420);

    // clk_en toggling 1-0-1 on the basic vector
    run_vec(16'h0100, 16'h0200, 16'h0100, 16'h0080, 16'h0000, 1, 2, 2, 1);
    check("toggle_value", out_result, 16'h0200);

    // randomized vectors
    for (int t = 0; t < 20; t++) begin
      run_vec(rnd_word(), rnd_word(), rnd_word(), rnd_word(), rnd_word(), 2,
              int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/neuron_driver.md
NEURON_DRIVER -- requirements
Module: neuron_driver

Interface
REQ-001 Parameters (one per line): name, default, meaning.
- n, 16, word width in bits.
- m, 8, fractional bits; passed through only, no arithmetic here.
- number_of_input, 2, inputs per neuron (>=1).
- clog2_number_of_input, 1, index counter width (>=1).
- timeout, 2*number_of_input+4, maximum cycles spent waiting for nrn_ready.
REQ-002 Ports (one per line): name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-high reset.
- clk_en, in, 1, clock enable.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, input beat accepted.
- in_data, in, n, data word.
- in_weight, in, n, weight word.
- in_bias, in, n, bias; sampled on beat 0 only.
- nrn_datas, out, number_of_input*n, packed data bus to the neuron.
- nrn_weights, out, number_of_input*n, packed weight bus to the neuron.
- nrn_bias, out, n, bias to the neuron.
- nrn_rst, out, 1, neuron reset and hold.
- nrn_result, in, n, neuron result.
- nrn_ready, in, 1, neuron result valid.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts the result.
- out_result, out, n, captured neuron result.
- busy, out, 1, high in any state other than IDLE.
- error, out, 1, sticky timeout flag.

Function
REQ-003 The FSM SHALL have five states: IDLE, LOAD, FIRE, WAIT, HOLD.
REQ-004 The FSM SHALL advance, and counters and registers SHALL update, only on edges where clk_en=1. With clk_en=0, all state SHALL hold.
REQ-005 in_ready SHALL equal (state==IDLE or state==LOAD) AND clk_en.
REQ-006 A beat transfers when in_valid and in_ready are both high.
REQ-007 Beat k SHALL write in_data to nrn_datas[k*n +: n] and in_weight to nrn_weights[k*n +: n]. Beat 0 SHALL also load nrn_bias from in_bias.
REQ-008 Beat 0 SHALL move the FSM from IDLE to LOAD, or directly to FIRE when number_of_input==1. Beat number_of_input-1 SHALL move LOAD to FIRE and wrap the index counter to 0.
REQ-009 FIRE SHALL last exactly one enabled cycle and then move to WAIT.
REQ-010 nrn_rst SHALL be 1 in IDLE, LOAD and FIRE, and 0 in WAIT and HOLD.
REQ-011 In WAIT, nrn_ready=1 SHALL capture nrn_result into out_result and move to HOLD.
REQ-012 The wait counter SHALL clear on entry to WAIT. If it reaches timeout without nrn_ready, the block SHALL set error and return to IDLE with out_result unchanged.
REQ-013 out_valid SHALL be 1 only in HOLD. out_valid=1 with out_ready=1 (and clk_en=1) SHALL return the FSM to IDLE.
REQ-014 out_result and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-015 In IDLE, the packed buses SHALL retain their last values.
REQ-016 error SHALL be cleared only by rst. After setting error, the block SHALL keep operating normally.
REQ-017 The block SHALL accept no input during FIRE, WAIT and HOLD. A beat offered in those states SHALL be held off by in_ready=0 and not lost.

Reset
REQ-018 rst=1 SHALL immediately drive the outputs to: state IDLE, index 0, in_ready=0 while rst is high, nrn_rst=1, out_valid=0, out_result=0, nrn_datas/nrn_weights/nrn_bias=0, busy=0, error=0.
REQ-019 rst asserted mid-LOAD or mid-WAIT SHALL discard the partial vector. The first beat after reset SHALL be treated as beat 0.

Structure
REQ-020 The shared package mlp_pkg SHALL hold the FSM state encoding (3 bits) and the default word/fraction constants.
REQ-021 The FSM and its counters SHALL live in a single sub-module, neuron_driver_ctrl. Storage SHALL use the existing Register module.

Verification
REQ-022 The bench SHALL cover these directed scenarios (n=16, m=8, number_of_input=2, timeout=8, driving a real neuron):
- Basic vector: data {0x0100, 0x0200}, weights {0x0100, 0x0080}, bias 0x0000 -> out_result=0x0200 with out_valid.
- ReLU clamp: data {0x0100, 0x0100}, weights {0xFF00, 0xFF00}, bias 0x0000 -> out_result=0x0000.
- Backpressure: out_ready held 0 for 5 cycles -> out_valid and out_result stable; in_ready=0 until the cycle after acceptance.
- Timeout: nrn_ready tied 0 -> error=1 exactly 8 cycles after WAIT entry, FSM back in IDLE; the next vector then completes normally.
- Reset mid-LOAD after beat 0, followed by a fresh vector: result matches the fresh vector only.
- clk_en toggling 1-0-1 every cycle during a full transaction: same result as continuous clk_en, with the enabled-cycle count unchanged.
